// File: rtl/oflow_score_board_pkg.sv
// Shared types and default sizing for the K-best score board.
package oflow_score_board_pkg;

  localparam int SB_ROWS    = 32;
  localparam int SB_K       = 4;
  localparam int SB_SCORE_W = 11;
  localparam int SB_ID_W    = 12;
  localparam int SB_ROW_W   = $clog2(SB_ROWS);
  localparam int SB_PTR_W   = $clog2(SB_K);
  localparam int SB_CNT_W   = $clog2(SB_ROWS + 1);

  typedef struct packed {
    logic [SB_K-1:0][SB_SCORE_W-1:0] scores;
    logic [SB_K-1:0][SB_ID_W-1:0]    ids;
    logic [SB_PTR_W-1:0]             ptr;
    logic                            valid;
    logic                            ovr_flag;
    logic [SB_ID_W-1:0]              ovr_id;
  } row_entry_t;

endpackage

// File: rtl/oflow_sb_row.sv
// One bounding-box row: K candidates, candidate pointer and override ID.
module oflow_sb_row
  import oflow_score_board_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset_N,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [SB_K-1:0][SB_SCORE_W-1:0] scores_in,
  input  logic [SB_K-1:0][SB_ID_W-1:0]    ids_in,
  input  logic                            adv,
  input  logic                            set_ovr,
  input  logic [SB_ID_W-1:0]              new_id,
  output logic [SB_SCORE_W-1:0]           score,
  output logic [SB_ID_W-1:0]              eff_id,
  output logic                            exhausted,
  output logic                            valid
);

  localparam logic [SB_PTR_W-1:0] LAST_PTR = SB_PTR_W'(SB_K - 1);

  row_entry_t entry_q;

  // NOTE: every field, including the candidate storage, is reset so that no
  // stale candidate from a previous frame can leak out after reset_N.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      // NOTE: sequential state uses non-blocking assignments only.
      entry_q <= '0;
    end else if (clear) begin
      entry_q <= '0;
    end else if (wr_en) begin
      entry_q.scores   <= scores_in;
      entry_q.ids      <= ids_in;
      entry_q.ptr      <= '0;
      entry_q.valid    <= 1'b1;
      entry_q.ovr_flag <= 1'b0;
      entry_q.ovr_id   <= '0;
    end else if (entry_q.valid) begin
      // Advance and override are independent and may land together.
      if (adv && (entry_q.ptr != LAST_PTR)) entry_q.ptr <= entry_q.ptr + 1'b1;
      if (set_ovr) begin
        entry_q.ovr_flag <= 1'b1;
        entry_q.ovr_id   <= new_id;
      end
    end
  end

  assign valid     = entry_q.valid;
  assign score     = entry_q.valid ? entry_q.scores[entry_q.ptr] : '0;
  assign eff_id    = !entry_q.valid   ? '0 :
                     entry_q.ovr_flag ? entry_q.ovr_id : entry_q.ids[entry_q.ptr];
  assign exhausted = entry_q.valid && (entry_q.ptr == LAST_PTR);

endmodule

// File: rtl/oflow_kbest_score_board.sv
// K-best score board: per-row candidate store, CR pointer/override decode,
// combinational read ports, write-done pulse and occupancy count.
module oflow_kbest_score_board
  import oflow_score_board_pkg::*;
#(
  parameter int ROWS    = SB_ROWS,
  parameter int K       = SB_K,
  parameter int SCORE_W = SB_SCORE_W,
  parameter int ID_W    = SB_ID_W,
  localparam int ROW_W  = $clog2(ROWS),
  localparam int CNT_W  = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 ready_new_frame,
  input  logic                 start_score_board,
  input  logic [ROW_W-1:0]     row_sel_by_set,
  input  logic [K*SCORE_W-1:0] scores_in,
  input  logic [K*ID_W-1:0]    ids_in,
  output logic                 done_score_board,
  input  logic [ROW_W-1:0]     row_sel_from_cr,
  output logic [SCORE_W-1:0]   score_to_cr,
  output logic [ID_W-1:0]      id_to_cr,
  output logic                 exhausted_to_cr,
  input  logic [ROW_W-1:0]     row_to_change,
  input  logic                 advance_ptr,
  input  logic                 write_new_id,
  input  logic [ID_W-1:0]      new_id,
  input  logic [ROW_W-1:0]     row_sel_to_pe,
  output logic [ID_W-1:0]      id_to_buffer,
  output logic [ROWS*ID_W-1:0] id_out,
  output logic [ROWS-1:0]      row_valid,
  output logic [CNT_W-1:0]     rows_written
);

  logic [SCORE_W-1:0] row_score [ROWS];
  logic [ID_W-1:0]    row_id    [ROWS];
  logic [ROWS-1:0]    row_exh;

  // Priority clear > write > CR op is resolved inside each row.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    oflow_sb_row u_row (
      .clk       (clk),
      .reset_N   (reset_N),
      .clear     (ready_new_frame),
      .wr_en     (start_score_board && (row_sel_by_set == ROW_W'(g))),
      .scores_in (scores_in),
      .ids_in    (ids_in),
      .adv       (advance_ptr && (row_to_change == ROW_W'(g))),
      .set_ovr   (write_new_id && (row_to_change == ROW_W'(g))),
      .new_id    (new_id),
      .score     (row_score[g]),
      .eff_id    (row_id[g]),
      .exhausted (row_exh[g]),
      .valid     (row_valid[g])
    );
    assign id_out[g*ID_W +: ID_W] = row_id[g];
  end

  assign score_to_cr     = row_score[row_sel_from_cr];
  assign id_to_cr        = row_id[row_sel_from_cr];
  assign exhausted_to_cr = row_exh[row_sel_from_cr];
  assign id_to_buffer    = row_id[row_sel_to_pe];

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      done_score_board <= 1'b0;
      rows_written     <= '0;
    end else if (ready_new_frame) begin
      done_score_board <= 1'b0;
      rows_written     <= '0;
    end else begin
      done_score_board <= start_score_board;
      // Rewrites of an already-valid row do not count again.
      if (start_score_board && !row_valid[row_sel_by_set] &&
          (rows_written != CNT_W'(ROWS)))
        rows_written <= rows_written + 1'b1;
    end
  end

endmodule

// File: tb/tb_oflow_kbest_score_board.sv
// Directed bench for oflow_kbest_score_board with hand-computed expectations.
module tb_oflow_kbest_score_board;

  localparam int ROWS = 32, K = 4, SCORE_W = 11, ID_W = 12;
  localparam int ROW_W = 5, CNT_W = 6;

  logic                 clk = 1'b0;
  logic                 reset_N = 1'b0;
  logic                 ready_new_frame = 1'b0;
  logic                 start_score_board = 1'b0;
  logic [ROW_W-1:0]     row_sel_by_set = '0;
  logic [K*SCORE_W-1:0] scores_in = '0;
  logic [K*ID_W-1:0]    ids_in = '0;
  logic                 done_score_board;
  logic [ROW_W-1:0]     row_sel_from_cr = '0;
  logic [SCORE_W-1:0]   score_to_cr;
  logic [ID_W-1:0]      id_to_cr;
  logic                 exhausted_to_cr;
  logic [ROW_W-1:0]     row_to_change = '0;
  logic                 advance_ptr = 1'b0;
  logic                 write_new_id = 1'b0;
  logic [ID_W-1:0]      new_id = '0;
  logic [ROW_W-1:0]     row_sel_to_pe = '0;
  logic [ID_W-1:0]      id_to_buffer;
  logic [ROWS*ID_W-1:0] id_out;
  logic [ROWS-1:0]      row_valid;
  logic [CNT_W-1:0]     rows_written;

  int total = 0;
  int bad   = 0;

  oflow_kbest_score_board dut (
    .clk               (clk),
    .reset_N           (reset_N),
    .ready_new_frame   (ready_new_frame),
    .start_score_board (start_score_board),
    .row_sel_by_set    (row_sel_by_set),
    .scores_in         (scores_in),
    .ids_in            (ids_in),
    .done_score_board  (done_score_board),
    .row_sel_from_cr   (row_sel_from_cr),
    .score_to_cr       (score_to_cr),
    .id_to_cr          (id_to_cr),
    .exhausted_to_cr   (exhausted_to_cr),
    .row_to_change     (row_to_change),
    .advance_ptr       (advance_ptr),
    .write_new_id      (write_new_id),
    .new_id            (new_id),
    .row_sel_to_pe     (row_sel_to_pe),
    .id_to_buffer      (id_to_buffer),
    .id_out            (id_out),
    .row_valid         (row_valid),
    .rows_written      (rows_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ID_W-1:0] i0, i1, i2, i3,
                      input logic [SCORE_W-1:0] s0, s1, s2, s3);
    ids_in    = {i3, i2, i1, i0};
    scores_in = {s3, s2, s1, s0};
  endtask

  function automatic logic [ID_W-1:0] row_of(input int r);
    return id_out[r*ID_W +: ID_W];
  endfunction

  initial begin
    // Reset state
    #2;
    check("rst_id_out", 64'(id_out == '0), 64'd1);
    check("rst_valid", 64'(row_valid), 64'd0);
    check("rst_count", 64'(rows_written), 64'd0);
    check("rst_done", 64'(done_score_board), 64'd0);
    check("rst_cr_id", 64'(id_to_cr), 64'd0);
    check("rst_exh", 64'(exhausted_to_cr), 64'd0);
    reset_N = 1'b1;
    step();

    // Write row 3
    load(12'd10, 12'd20, 12'd30, 12'd40, 11'd2, 11'd5, 11'd7, 11'd9);
    start_score_board = 1'b1; row_sel_by_set = 5'd3;
    step();
    start_score_board = 1'b0;
    row_sel_from_cr = 5'd3;
    #1;
    check("wr3_done", 64'(done_score_board), 64'd1);
    check("wr3_id_out", 64'(row_of(3)), 64'd10);
    check("wr3_valid", 64'(row_valid), 64'h8);
    check("wr3_count", 64'(rows_written), 64'd1);
    check("wr3_score", 64'(score_to_cr), 64'd2);
    check("wr3_exh", 64'(exhausted_to_cr), 64'd0);
    step();
    check("done_pulse_end", 64'(done_score_board), 64'd0);

    // Advance through all candidates, then saturate
    advance_ptr = 1'b1; row_to_change = 5'd3;
    step(); check("adv1_id", 64'(id_to_cr), 64'd20);
    check("adv1_score", 64'(score_to_cr), 64'd5);
    step(); check("adv2_id", 64'(id_to_cr), 64'd30);
    step(); check("adv3_id", 64'(id_to_cr), 64'd40);
    check("adv3_exh", 64'(exhausted_to_cr), 64'd1);
    step(); check("adv4_id", 64'(id_to_cr), 64'd40);
    check("adv4_exh", 64'(exhausted_to_cr), 64'd1);
    check("adv4_score", 64'(score_to_cr), 64'd9);
    advance_ptr = 1'b0;

    // Override ID, then rewrite restores candidate 0
    write_new_id = 1'b1; new_id = 12'h7FF; row_sel_to_pe = 5'd3;
    step();
    write_new_id = 1'b0;
    check("ovr_id_out", 64'(row_of(3)), 64'h7FF);
    check("ovr_buffer", 64'(id_to_buffer), 64'h7FF);
    check("ovr_score", 64'(score_to_cr), 64'd9);
    start_score_board = 1'b1; row_sel_by_set = 5'd3;
    step();
    start_score_board = 1'b0;
    check("rewr_id", 64'(id_to_cr), 64'd10);
    check("rewr_score", 64'(score_to_cr), 64'd2);
    check("rewr_exh", 64'(exhausted_to_cr), 64'd0);
    check("rewr_count", 64'(rows_written), 64'd1);

    // Start and advance on the same row: write wins
    load(12'h51, 12'h52, 12'h53, 12'h54, 11'd1, 11'd3, 11'd4, 11'd6);
    start_score_board = 1'b1; row_sel_by_set = 5'd5;
    advance_ptr = 1'b1; row_to_change = 5'd5;
    step();
    row_sel_from_cr = 5'd5;
    #1;
    check("same_row_id", 64'(id_to_cr), 64'h51);
    check("same_row_score", 64'(score_to_cr), 64'd1);
    check("same_row_count", 64'(rows_written), 64'd2);

    // Start on row 6 and advance on row 3: both apply
    load(12'h61, 12'h62, 12'h63, 12'h64, 11'd8, 11'd9, 11'd10, 11'd11);
    row_sel_by_set = 5'd6; row_to_change = 5'd3;
    step();
    start_score_board = 1'b0; advance_ptr = 1'b0;
    row_sel_from_cr = 5'd3;
    #1;
    check("diff_row3_id", 64'(id_to_cr), 64'd20);
    check("diff_row6_id", 64'(row_of(6)), 64'h61);
    check("diff_valid", 64'(row_valid), 64'h68);
    check("diff_count", 64'(rows_written), 64'd3);

    // CR ops on an invalid row are ignored
    advance_ptr = 1'b1; write_new_id = 1'b1; new_id = 12'h123; row_to_change = 5'd7;
    row_sel_from_cr = 5'd7;
    step();
    advance_ptr = 1'b0; write_new_id = 1'b0;
    check("inv_row_id", 64'(id_to_cr), 64'd0);
    check("inv_row_valid", 64'(row_valid), 64'h68);

    // Fill every row back-to-back; done stays high
    for (int r = 0; r < ROWS; r++) begin
      load(ID_W'(100 + r), 12'd1, 12'd2, 12'd3, SCORE_W'(r), 11'd40, 11'd41, 11'd42);
      start_score_board = 1'b1; row_sel_by_set = ROW_W'(r);
      step();
      if (r == 0 || r == 17 || r == ROWS - 1)
        check($sformatf("fill_done_%0d", r), 64'(done_score_board), 64'd1);
    end
    check("fill_count", 64'(rows_written), 64'd32);
    check("fill_valid", 64'(row_valid), 64'hFFFF_FFFF);
    check("fill_row31", 64'(row_of(31)), 64'd131);
    check("fill_row3", 64'(row_of(3)), 64'd103);
    row_sel_by_set = 5'd0;
    step();
    check("full_rewrite_count", 64'(rows_written), 64'd32);
    check("count_bound", 64'(rows_written <= CNT_W'(ROWS)), 64'd1);

    // Frame clear beats a simultaneous start
    ready_new_frame = 1'b1; row_sel_by_set = 5'd0;
    step();
    ready_new_frame = 1'b0; start_score_board = 1'b0;
    row_sel_to_pe = 5'd0;
    #1;
    check("clr_done", 64'(done_score_board), 64'd0);
    check("clr_count", 64'(rows_written), 64'd0);
    check("clr_valid", 64'(row_valid), 64'd0);
    check("clr_id_out", 64'(id_out == '0), 64'd1);
    check("clr_buffer", 64'(id_to_buffer), 64'd0);

    // Asynchronous reset mid-frame
    load(12'd10, 12'd20, 12'd30, 12'd40, 11'd2, 11'd5, 11'd7, 11'd9);
    start_score_board = 1'b1; row_sel_by_set = 5'd3;
    step();
    start_score_board = 1'b0;
    row_sel_from_cr = 5'd3;
    advance_ptr = 1'b1; row_to_change = 5'd3;
    step();
    advance_ptr = 1'b0;
    check("pre_rst_id", 64'(id_to_cr), 64'd20);
    #1 reset_N = 1'b0;
    #1;
    check("arst_id", 64'(id_to_cr), 64'd0);
    check("arst_valid", 64'(row_valid), 64'd0);
    check("arst_count", 64'(rows_written), 64'd0);
    reset_N = 1'b1;
    advance_ptr = 1'b1; row_to_change = 5'd3;
    step();
    advance_ptr = 1'b0;
    check("post_rst_adv_id", 64'(id_to_cr), 64'd0);
    check("post_rst_adv_exh", 64'(exhausted_to_cr), 64'd0);
    start_score_board = 1'b1; row_sel_by_set = 5'd3;
    step();
    start_score_board = 1'b0;
    check("post_rst_wr_id", 64'(id_to_cr), 64'd10);
    check("post_rst_count", 64'(rows_written), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oflow_kbest_score_board.md
# oflow_kbest_score_board

Parametrised successor to the two-candidate score board. Holds, per bounding-box row of the current frame, the K lowest-score (score, ID) matches from registration. It also holds a per-row candidate pointer that conflict resolution advances, and an optional override ID for rows whose candidates are exhausted. It sits between the registration FSM/PEs, the conflict-resolve block, the MEM buffer and the core's ID output bus.

## Interface
- ROWS, 32, rows (bboxes per frame); ROW_W = $clog2(ROWS)
- K, 4, candidates per row, K ≥ 2; PTR_W = $clog2(K)
- SCORE_W, 11, score width
- ID_W, 12, object-ID width
- CNT_W = $clog2(ROWS+1), derived, width of the occupancy count
- clk  in  1  clock
- reset_N  in  1  reset, asynchronous, active-low
- ready_new_frame  in  1  synchronous frame clear
- start_score_board  in  1  write request from registration FSM
- row_sel_by_set  in  ROW_W  row to write
- scores_in  in  K*SCORE_W  candidate scores, slot 0 in LSBs, ascending score order (upstream guarantee)
- ids_in  in  K*ID_W  candidate IDs, same slot order
- done_score_board  out  1  write-complete pulse
- row_sel_from_cr  in  ROW_W  CR read row
- score_to_cr  out  SCORE_W  score of the current candidate of row_sel_from_cr
- id_to_cr  out  ID_W  effective ID of row_sel_from_cr
- exhausted_to_cr  out  1  row_sel_from_cr pointer is at K-1
- row_to_change  in  ROW_W  CR target row
- advance_ptr  in  1  move row_to_change to its next candidate
- write_new_id  in  1  set override ID on row_to_change
- new_id  in  ID_W  override ID value
- row_sel_to_pe  in  ROW_W  buffer read row
- id_to_buffer  out  ID_W  effective ID of row_sel_to_pe
- id_out  out  ROWS*ID_W  effective ID of every row, row i at [i*ID_W +: ID_W]
- row_valid  out  ROWS  row written this frame
- rows_written  out  CNT_W  count of valid rows

## Operation
- Per-row state: K scores, K IDs, ptr (PTR_W), valid, ovr_flag, ovr_id.
- Effective ID = ovr_id if ovr_flag is set, else ids[ptr]. Score output is always scores[ptr].
- Write (start_score_board): load all K slots; ptr←0; ovr_flag←0; valid←1. rows_written increments only if the row was previously invalid. A rewrite of a valid row replaces its contents and does not count again.
- advance_ptr: if ptr<K-1, ptr←ptr+1; at K-1, ptr holds (saturates). CR then uses exhausted_to_cr to decide whether to issue write_new_id.
- write_new_id: ovr_id←new_id; ovr_flag←1; ptr is unchanged.
- advance_ptr and write_new_id in the same cycle on the same row: both apply.
- A CR op on a row with valid=0 is ignored. Its outputs read as all-zero.
- Priority: ready_new_frame > start_score_board > CR ops.
  - Start and a CR op to the same row in the same cycle: only the write takes effect.
  - Different rows in the same cycle: both take effect.
- ready_new_frame clears all row state, rows_written and done_score_board in one cycle.

## Timing
- Reset (asynchronous, reset_N low): all storage 0, all outputs 0. Read outputs are 0 because valid=0.
- All reads are combinational from registers. Values written at edge N are visible after edge N.
- done_score_board is a 1-cycle pulse, one cycle after start_score_board is sampled.
  - Back-to-back starts give a continuous high, one cycle per accepted write.
  - It is suppressed if ready_new_frame is sampled in the same cycle as start.
- A reset assertion mid-frame discards everything; no partial state survives.
- rows_written saturates at ROWS. This is unreachable by construction; the bench asserts it.

## Structure
- Shared package oflow_score_board_pkg: row_entry_t struct (scores, ids, ptr, valid, ovr_flag, ovr_id), parametrised through localparams, plus the default parameter constants.
- One sub-module, oflow_sb_row: per-row storage and pointer/override logic, instantiated ROWS times via generate.
- The top holds the write/CR decode, read muxes, done pulse and occupancy counter.

## Test plan
- Reset, then write row 3 with ids {40,30,20,10} (slot0=10), scores {9,7,5,2} → done pulse next cycle; id_out row 3 = 10, row_valid[3]=1, rows_written=1.
- Three advance_ptr on row 3 → id_to_cr 20, 30, 40. A fourth advance holds 40, exhausted_to_cr=1, score_to_cr=9.
- write_new_id row 3 with new_id=0x7FF → id_out row 3 = 0x7FF. A rewrite of row 3 then restores id 10, ptr 0, and rows_written stays 1.
- Same cycle: start on row 5 and advance_ptr on row 5 → row 5 ptr=0. Then start on row 6 plus advance on row 3 → both applied.
- Fill all 32 rows, then assert ready_new_frame together with a start → everything 0, no done pulse, rows_written=0.
- Assert reset_N low mid-sequence between clock edges → outputs 0 immediately. After release, advance_ptr on a cleared row has no effect.
